// File: rtl/up_down_count_checker.sv
// Receive-side monitor for a W-bit up/down counter. Runs a cycle-accurate model
// of the counter, flags divergence, reports verified wraps, and latches a
// sticky FAULT once the saturating error total reaches ERR_LIMIT.
module up_down_count_checker #(
  parameter int W         = 4,
  parameter int ERR_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             obs_rst,
  input  logic             up_down,
  input  logic             load_en,
  input  logic [W-1:0]     load_value,
  input  logic [W-1:0]     count,
  output logic [W-1:0]     expected,
  output logic             mismatch,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [ERR_W-1:0] err_count,
  output logic             locked,
  output logic             fault
);

  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] LIMIT   = ERR_W'(ERR_LIMIT);
  localparam logic [W-1:0]     CNT_MAX = {W{1'b1}};

  state_t           state_q, state_d;
  logic [W-1:0]     exp_q, exp_d;
  logic             mm_q, mm_d;
  logic             wu_q, wu_d;
  logic             wd_q, wd_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             locked_q, fault_q;

  logic [W-1:0]     nxt_cnt, nxt_exp;
  logic [ERR_W-1:0] err_inc;

  // Counter step rule applied to the observed count and to the model's own value
  always_comb begin
    nxt_cnt = obs_rst ? '0 : load_en ? load_value : up_down ? count + 1'b1 : count - 1'b1;
    nxt_exp = obs_rst ? '0 : load_en ? load_value : up_down ? exp_q + 1'b1 : exp_q - 1'b1;
    err_inc = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
  end

  // Next-state, model update and pulse generation
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mm_d    = 1'b0;
    wu_d    = 1'b0;
    wd_d    = 1'b0;
    err_d   = err_q;
    if (clear) begin
      err_d   = '0;
      exp_d   = nxt_cnt;
      state_d = ACQUIRE;
    end else begin
      case (state_q)
        ACQUIRE: begin
          exp_d   = nxt_cnt;
          state_d = TRACK;
        end
        TRACK: begin
          if (obs_rst) begin
            exp_d = '0;
          end else if (count != exp_q) begin
            // Resync to the observed value so one slip costs one error
            mm_d  = 1'b1;
            err_d = err_inc;
            exp_d = nxt_cnt;
          end else begin
            exp_d = nxt_exp;
            wu_d  = !load_en &&  up_down && (count == CNT_MAX);
            wd_d  = !load_en && !up_down && (count == '0);
          end
          if (err_d >= LIMIT) state_d = FAULT;
        end
        FAULT: begin
          exp_d = nxt_cnt;
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACQUIRE;
      exp_q    <= '0;
      mm_q     <= 1'b0;
      wu_q     <= 1'b0;
      wd_q     <= 1'b0;
      err_q    <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      mm_q     <= mm_d;
      wu_q     <= wu_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      locked_q <= (state_d == TRACK);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign expected  = exp_q;
  assign mismatch  = mm_q;
  assign wrap_up   = wu_q;
  assign wrap_down = wd_q;
  assign err_count = err_q;
  assign locked    = locked_q;
  assign fault     = fault_q;

endmodule
